// File: rtl/comb_sweep_if.sv
// Bundle between the sweep sequencer and its surroundings: self-test control,
// shared stimulus, the two compared outputs, and the sweep results.
interface comb_sweep_if #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 1
);
    logic            start;
    logic            abort;
    logic [IN_W-1:0] stim;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] ref_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [IN_W:0]   score;
    logic            fail_seen;
    logic [IN_W-1:0] first_fail;

    // Controller / environment side: requests sweeps and returns model outputs.
    modport master (
        output start, abort, dut_out, ref_out,
        input  stim, busy, done, pass, score, fail_seen, first_fail
    );

    // Sequencer side.
    modport slave (
        input  start, abort, dut_out, ref_out,
        output stim, busy, done, pass, score, fail_seen, first_fail
    );
endinterface

// File: rtl/comb_sweep_sequencer.sv
// Exhaustive input sweeper: walks every input code, waits a settle time, then
// scores the block under test against its golden model and reports a verdict.
module comb_sweep_sequencer #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    comb_sweep_if.slave bus
);
    localparam int unsigned SCORE_W = IN_W + 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CODES   = 1 << IN_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IN_W-1:0]    r_stim;
    logic [IN_W-1:0]    w_stim_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic               r_fail_seen;
    logic               w_fail_seen_nxt;
    logic [IN_W-1:0]    r_first_fail;
    logic [IN_W-1:0]    w_first_fail_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_start;
    logic               w_abort;
    logic [OUT_W-1:0]   w_dut;
    logic [OUT_W-1:0]   w_ref;
    logic               w_match;
    logic               w_last_code;
    logic               w_settled;

    assign w_start     = bus.start;
    assign w_abort     = bus.abort;
    assign w_dut       = bus.dut_out;
    assign w_ref       = bus.ref_out;
    assign w_match     = (w_dut == w_ref);
    assign w_last_code = (r_stim == {IN_W{1'b1}});
    assign w_settled   = (r_cnt == CNT_W'(SETTLE - 1));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort takes priority over the settle/last-code exits.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_settled) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last_code) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values. The compare is scored even when aborted.
    always_comb begin
        w_stim_nxt       = r_stim;
        w_cnt_nxt        = r_cnt;
        w_score_nxt      = r_score;
        w_fail_seen_nxt  = r_fail_seen;
        w_first_fail_nxt = r_first_fail;
        w_busy_nxt       = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_COMPARE);
        w_done_nxt       = (w_state_nxt == ST_DONE);
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_stim_nxt       = '0;
                    w_cnt_nxt        = '0;
                    w_score_nxt      = '0;
                    w_fail_seen_nxt  = 1'b0;
                    w_first_fail_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (w_abort) begin
                    w_stim_nxt = '0;
                    w_cnt_nxt  = '0;
                end else if (w_settled) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_COMPARE: begin
                w_cnt_nxt = '0;
                if (w_match) begin
                    w_score_nxt = r_score + SCORE_W'(1);
                end else if (!r_fail_seen) begin
                    w_fail_seen_nxt  = 1'b1;
                    w_first_fail_nxt = r_stim;
                end
                if (w_abort) begin
                    w_stim_nxt = '0;
                end else if (!w_last_code) begin
                    w_stim_nxt = r_stim + IN_W'(1);
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stim       <= '0;
            r_cnt        <= '0;
            r_score      <= '0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_stim       <= w_stim_nxt;
            r_cnt        <= w_cnt_nxt;
            r_score      <= w_score_nxt;
            r_fail_seen  <= w_fail_seen_nxt;
            r_first_fail <= w_first_fail_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.stim       = r_stim;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.score      = r_score;
    assign bus.fail_seen  = r_fail_seen;
    assign bus.first_fail = r_first_fail;
    // Verdict is a live decode of the final score, only meaningful while done.
    assign bus.pass       = r_done && (r_score == SCORE_W'(CODES));

endmodule

// File: tb/tb_comb_sweep_sequencer.sv
// Directed and randomized checks of comb_sweep_sequencer against a counting
// model of the sweep, for the default build and a 1-bit / 2-bit / settle-1 build.
module tb_comb_sweep_sequencer;
    localparam int unsigned A_IN_W   = 3;
    localparam int unsigned A_OUT_W  = 1;
    localparam int unsigned A_SETTLE = 2;
    localparam int          A_CODES  = 8;
    localparam int          A_PER    = 3;
    localparam int unsigned B_IN_W   = 1;
    localparam int unsigned B_OUT_W  = 2;
    localparam int unsigned B_SETTLE = 1;
    localparam int          B_CODES  = 2;
    localparam int          B_PER    = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] mask_a;
    logic [1:0] mask_b;
    int         n_tests = 0;
    int         n_fail  = 0;

    comb_sweep_if #(.IN_W(A_IN_W), .OUT_W(A_OUT_W)) bus_a ();
    comb_sweep_if #(.IN_W(B_IN_W), .OUT_W(B_OUT_W)) bus_b ();

    comb_sweep_sequencer #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .SETTLE(A_SETTLE)) u_dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a)
    );

    comb_sweep_sequencer #(.IN_W(B_IN_W), .OUT_W(B_OUT_W), .SETTLE(B_SETTLE)) u_dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    // Golden mux function; the block under test inverts it on masked codes.
    assign bus_a.ref_out = (bus_a.stim[0] & bus_a.stim[1]) | (~bus_a.stim[0] & bus_a.stim[2]);
    assign bus_a.dut_out = bus_a.ref_out ^ mask_a[bus_a.stim];
    assign bus_b.ref_out = {bus_b.stim, ~bus_b.stim};
    assign bus_b.dut_out = bus_b.ref_out ^ (mask_b[bus_b.stim] ? 2'b10 : 2'b00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result of scoring the first n_codes codes given the set of faulty codes.
    function automatic void model(input logic [7:0] mask, input int n_codes,
                                  output int sc, output int ff, output int fs);
        sc = 0;
        ff = 0;
        fs = 0;
        for (int c = 0; c < n_codes; c++) begin
            if (mask[c]) begin
                if (fs == 0) begin
                    fs = 1;
                    ff = c;
                end
            end else begin
                sc++;
            end
        end
    endfunction

    task automatic chk_results_a(input string tag, input logic [7:0] mask, input int n_codes);
        int sc, ff, fs;
        model(mask, n_codes, sc, ff, fs);
        chk({tag, "_score"}, 32'(bus_a.score), 32'(sc));
        chk({tag, "_fail_seen"}, 32'(bus_a.fail_seen), 32'(fs));
        chk({tag, "_first_fail"}, 32'(bus_a.first_fail), 32'(ff));
    endtask

    // Full sweep on instance A, starting from IDLE or DONE; checks every cycle.
    task automatic sweep_a(input string tag, input logic [7:0] mask, input bit hold);
        int sc, ff, fs;
        mask_a = mask;
        bus_a.start = 1'b1;
        @(negedge clk);
        if (!hold) bus_a.start = 1'b0;
        for (int j = 0; j < A_CODES * A_PER; j++) begin
            chk({tag, "_busy"}, 32'(bus_a.busy), 32'd1);
            chk({tag, "_done"}, 32'(bus_a.done), 32'd0);
            chk({tag, "_pass"}, 32'(bus_a.pass), 32'd0);
            chk({tag, "_stim"}, 32'(bus_a.stim), 32'(j / A_PER));
            chk_results_a(tag, mask, j / A_PER);
            @(negedge clk);
        end
        model(mask, A_CODES, sc, ff, fs);
        chk({tag, "_end_done"}, 32'(bus_a.done), 32'd1);
        chk({tag, "_end_busy"}, 32'(bus_a.busy), 32'd0);
        chk({tag, "_end_stim"}, 32'(bus_a.stim), 32'(A_CODES - 1));
        chk({tag, "_end_pass"}, 32'(bus_a.pass), 32'(sc == A_CODES));
        chk_results_a({tag, "_end"}, mask, A_CODES);
    endtask

    task automatic sweep_b(input string tag, input logic [1:0] mask);
        int sc, ff, fs;
        mask_b = mask;
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        for (int j = 0; j < B_CODES * B_PER; j++) begin
            chk({tag, "_busy"}, 32'(bus_b.busy), 32'd1);
            chk({tag, "_done"}, 32'(bus_b.done), 32'd0);
            chk({tag, "_stim"}, 32'(bus_b.stim), 32'(j / B_PER));
            @(negedge clk);
        end
        model({6'd0, mask}, B_CODES, sc, ff, fs);
        chk({tag, "_end_done"}, 32'(bus_b.done), 32'd1);
        chk({tag, "_end_busy"}, 32'(bus_b.busy), 32'd0);
        chk({tag, "_end_score"}, 32'(bus_b.score), 32'(sc));
        chk({tag, "_end_pass"}, 32'(bus_b.pass), 32'(sc == B_CODES));
        chk({tag, "_end_fail_seen"}, 32'(bus_b.fail_seen), 32'(fs));
        chk({tag, "_end_first_fail"}, 32'(bus_b.first_fail), 32'(ff));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_stim"}, 32'(bus_a.stim), 32'd0);
        chk({tag, "_a_busy"}, 32'(bus_a.busy), 32'd0);
        chk({tag, "_a_done"}, 32'(bus_a.done), 32'd0);
        chk({tag, "_a_pass"}, 32'(bus_a.pass), 32'd0);
        chk({tag, "_a_score"}, 32'(bus_a.score), 32'd0);
        chk({tag, "_a_fail_seen"}, 32'(bus_a.fail_seen), 32'd0);
        chk({tag, "_a_first_fail"}, 32'(bus_a.first_fail), 32'd0);
        chk({tag, "_b_busy"}, 32'(bus_b.busy), 32'd0);
        chk({tag, "_b_score"}, 32'(bus_b.score), 32'd0);
    endtask

    initial begin
        logic [7:0] rmask;
        logic [31:0] held_score;
        rstn        = 1'b0;
        mask_a      = 8'd0;
        mask_b      = 2'd0;
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;

        // Reset and quiet idle.
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus_a.busy), 32'd0);
            chk("idle_done", 32'(bus_a.done), 32'd0);
        end

        // Matching models, then the faulty block, then a restart from DONE.
        sweep_a("match", 8'h00, 1'b0);
        sweep_a("faulty", 8'b0100_1000, 1'b0);
        sweep_a("restart", 8'b0100_1000, 1'b0);

        // Abort has no effect in DONE.
        held_score  = 32'(bus_a.score);
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        chk("done_abort_done", 32'(bus_a.done), 32'd1);
        chk("done_abort_score", 32'(bus_a.score), held_score);

        // Abort during the compare of code 4: that compare still counts.
        rmask       = 8'($urandom_range(0, 255));
        mask_a      = rmask;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int j = 0; j < 4 * A_PER + A_SETTLE; j++) @(negedge clk);
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_cmp_busy", 32'(bus_a.busy), 32'd0);
            chk("abort_cmp_done", 32'(bus_a.done), 32'd0);
            chk("abort_cmp_stim", 32'(bus_a.stim), 32'd0);
            chk_results_a("abort_cmp", rmask, 5);
            @(negedge clk);
        end
        sweep_a("after_abort", rmask, 1'b0);

        // Abort during the settle of code 1: only code 0 scored.
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int j = 0; j < A_PER + 1; j++) @(negedge clk);
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        chk("abort_set_busy", 32'(bus_a.busy), 32'd0);
        chk("abort_set_stim", 32'(bus_a.stim), 32'd0);
        chk_results_a("abort_set", rmask, 1);

        // Reset in the middle of code 2 clears everything without a clock edge.
        sweep_a("pre_reset", 8'h00, 1'b0);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int j = 0; j < 2 * A_PER + 1; j++) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_busy", 32'(bus_a.busy), 32'd0);
            chk("post_reset_stim", 32'(bus_a.stim), 32'd0);
            chk("post_reset_done", 32'(bus_a.done), 32'd0);
        end

        // Randomized fault patterns.
        for (int r = 0; r < 3; r++) begin
            sweep_a("random", 8'($urandom_range(0, 255)), 1'b0);
        end

        // start held high: the next sweep begins right after one DONE cycle.
        sweep_a("hold", 8'h00, 1'b1);
        @(negedge clk);
        chk("hold_next_busy", 32'(bus_a.busy), 32'd1);
        chk("hold_next_done", 32'(bus_a.done), 32'd0);
        chk("hold_next_stim", 32'(bus_a.stim), 32'd0);
        chk("hold_next_score", 32'(bus_a.score), 32'd0);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        chk("hold_abort_busy", 32'(bus_a.busy), 32'd0);

        // Narrow build: two codes, two-bit outputs, one settle cycle.
        sweep_b("narrow", 2'b00);
        sweep_b("narrow_fault", 2'b10);
        sweep_b("narrow_rand", 2'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_sweep_sequencer.md
# comb_sweep_sequencer

Exhaustive stimulus sequencer and scorer for small combinational blocks. It drives one shared input vector into a block under test and its golden gate-level model. After a programmable settle time it compares their outputs and counts matches over all 2^IN_W input codes. At the end it reports a pass/fail verdict and the first failing code. It sits between a top-level self-test controller (start/done) and any pair of combinational modules with matching port shapes.

## Interface
- IN_W, 3, width of the swept input vector; legal range 1–8.
- OUT_W, 1, width of the compared outputs; legal range 1–16.
- SETTLE, 2, cycles the input is held before the compare cycle; legal range 1–15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  sweep request; sampled only in IDLE and DONE.
- abort  in  1  synchronous abort; in SETTLE or COMPARE, returns the block to IDLE on the next edge.
- stim  out  IN_W  vector driven to both the block under test and the golden model.
- dut_out  in  OUT_W  output of the block under test.
- ref_out  in  OUT_W  output of the golden model.
- busy  out  1  high in SETTLE and COMPARE.
- done  out  1  high while in DONE.
- pass  out  1  valid while done; 1 iff score == 2^IN_W.
- score  out  IN_W+1  count of matching codes.
- fail_seen  out  1  set on the first mismatch of a sweep.
- first_fail  out  IN_W  stim value of the first mismatch; holds 0 until fail_seen.

## Operation
- Reset values: state IDLE, stim 0, busy 0, done 0, pass 0, score 0, fail_seen 0, first_fail 0, settle counter 0. Reset takes effect immediately, including mid-sweep.
- FSM states: IDLE, SETTLE, COMPARE, DONE.
- IDLE → SETTLE on start:
  - stim ← 0, score ← 0, fail_seen ← 0, first_fail ← 0, counter ← 0.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE-1: counter ← 0, go to COMPARE.
  - stim is held constant.
- COMPARE, for exactly one cycle:
  - Sample dut_out and ref_out with a full OUT_W bitwise compare.
  - Equal: score ← score+1.
  - Not equal and fail_seen == 0: fail_seen ← 1, first_fail ← stim.
  - Later mismatches change only the score, which does not increment.
  - If stim == all ones: go to DONE; stim holds its final value.
  - Otherwise: stim ← stim+1, go to SETTLE.
- DONE:
  - done = 1.
  - pass = (score == 2^IN_W), computed combinationally from score and gated by done.
  - All results hold.
  - start → restart exactly as from IDLE (same cycle effects); done drops on that edge.
- Start behaviour:
  - start is ignored while busy.
  - start held high continuously causes back-to-back sweeps, one idle-free DONE cycle apart.
- abort in SETTLE or COMPARE:
  - Next edge: IDLE, busy 0.
  - score, fail_seen and first_fail keep their partial values; stim ← 0.
  - abort wins over a simultaneous COMPARE→DONE transition. The compare in that cycle is still scored.
  - abort has no effect in IDLE or DONE.
- Width rules:
  - score is IN_W+1 bits and cannot overflow (maximum 2^IN_W).
  - stim never wraps, because the last-code test precedes the increment.

## Timing
- start sampled high in IDLE at edge k: busy is high from k, stim = 0 from k.
- Per code: SETTLE+1 cycles. The compare uses the values present during the COMPARE cycle, SETTLE cycles after stim changed.
- DONE is entered at edge k + 2^IN_W·(SETTLE+1). With the defaults that is k+24.
- score updates on the edge that ends each COMPARE cycle.
- done/pass are valid starting with the first DONE cycle.
- All outputs are registered except pass.

## Test plan
- **Reset:** rstn low → every output 0. Release, then hold start low for 10 cycles → stays IDLE, busy 0.
- **Matching models:** defaults, dut_out = ref_out = (a&b)|(~a&c), with a = stim[0], b = stim[1], c = stim[2]; pulse start.
  - Required: busy for 24 cycles, stim steps 0..7 every 3 cycles, done at cycle 24, score 8, pass 1, fail_seen 0.
- **Faulty block:** dut_out = ref_out except inverted for codes 3 and 6.
  - Required: score 6, pass 0, fail_seen 1, first_fail 3.
- **Abort:** pulse start, then assert abort during the COMPARE of code 4.
  - Required: next edge IDLE, busy 0, done 0, score 5, stim 0.
  - A later start must restart from stim 0 with score cleared.
- **Reset mid-sweep:** rstn low during code 2.
  - Required: all outputs 0 immediately; after release, block stays IDLE.
- **Restart and parameters:** in DONE, pulse start → done drops on that edge and a fresh sweep gives the same result.
  - Repeat with IN_W=1, OUT_W=2, SETTLE=1 → DONE after 4 cycles, score 2.
